// File: rtl/ctrl_recirculador_pkg.sv
// Shared constants and state encodings for the recirculator control path.
// Also imported by the serial-to-parallel block.
package ctrl_recirculador_pkg;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_ALIGN  = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

  localparam logic [7:0] COMMA_K28_5 = 8'hBC;
  localparam int ALIGN_COUNT_DEF = 4;
  localparam int LOSS_COUNT_DEF  = 4;

endpackage

// File: rtl/byte_packer.sv
// Packs bytes into 32-bit words, first byte in [31:24].
// Emits a one-cycle valid when the 4th lane is filled.
module byte_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  byte_in,
  input  logic        load,
  input  logic        clear,
  output logic [31:0] data_out,
  output logic        valid_out,
  output logic [1:0]  byte_idx
);

  logic [23:0] acc;

  always_ff @(posedge clk) begin
    if (!reset) begin
      acc       <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      byte_idx  <= '0;
    end else begin
      valid_out <= 1'b0;
      if (clear) begin
        byte_idx <= '0;
      end else if (load) begin
        byte_idx <= byte_idx + 2'd1;
        unique case (byte_idx)
          2'd0: acc[23:16] <= byte_in;
          2'd1: acc[15:8]  <= byte_in;
          2'd2: acc[7:0]   <= byte_in;
          2'd3: begin
            data_out  <= {acc, byte_in};
            valid_out <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/ctrl_recirculador.sv
// Lane alignment FSM feeding the recirculator: comma-based lock,
// word packing while active, and loss of lock on sustained idle.
module ctrl_recirculador
  import ctrl_recirculador_pkg::*;
#(
  parameter logic [7:0] COMMA = COMMA_K28_5,
  parameter int ALIGN_COUNT = ALIGN_COUNT_DEF,
  parameter int LOSS_COUNT  = LOSS_COUNT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        active,
  output logic [31:0] data_out,
  output logic        valid_out,
  output logic        err_partial,
  output logic [1:0]  state_out
);

  localparam logic [3:0] ALIGN_N = 4'(ALIGN_COUNT);
  localparam logic [3:0] LOSS_N  = 4'(LOSS_COUNT);

  state_t     state;
  logic [3:0] comma_cnt;
  logic [3:0] idle_cnt;
  logic [1:0] byte_idx;
  logic       is_comma;
  logic       is_data;
  logic       lost;
  logic       load;
  logic       clear;

  assign is_comma = byte_valid && (byte_in == COMMA);
  assign is_data  = byte_valid && (byte_in != COMMA);
  assign lost     = !byte_valid && (idle_cnt + 4'd1 == LOSS_N);
  assign load     = (state == ST_ACTIVE) && is_data;
  // Any exit from ACTIVE or mid-word comma rewinds the packer.
  assign clear    = (state != ST_ACTIVE) || lost ||
                    (is_comma && byte_idx != 2'd0);
  assign state_out = state;

  byte_packer u_packer (
    .clk       (clk),
    .reset     (reset),
    .byte_in   (byte_in),
    .load      (load),
    .clear     (clear),
    .data_out  (data_out),
    .valid_out (valid_out),
    .byte_idx  (byte_idx)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= ST_SEARCH;
      comma_cnt   <= '0;
      idle_cnt    <= '0;
      active      <= 1'b0;
      err_partial <= 1'b0;
    end else begin
      err_partial <= 1'b0;
      case (state)
        ST_SEARCH: begin
          idle_cnt <= '0;
          if (is_comma) begin
            comma_cnt <= 4'd1;
            if (ALIGN_N == 4'd1) begin
              state  <= ST_ACTIVE;
              active <= 1'b1;
            end else begin
              state <= ST_ALIGN;
            end
          end
        end
        ST_ALIGN: begin
          if (is_comma) begin
            comma_cnt <= comma_cnt + 4'd1;
            if (comma_cnt + 4'd1 == ALIGN_N) begin
              state    <= ST_ACTIVE;
              active   <= 1'b1;
              idle_cnt <= '0;
            end
          end else if (is_data) begin
            comma_cnt <= '0;
            state     <= ST_SEARCH;
          end
        end
        ST_ACTIVE: begin
          if (byte_valid) begin
            idle_cnt <= '0;
            if (is_comma && byte_idx != 2'd0)
              err_partial <= 1'b1;
          end else if (lost) begin
            state     <= ST_SEARCH;
            active    <= 1'b0;
            comma_cnt <= '0;
            idle_cnt  <= '0;
          end else begin
            idle_cnt <= idle_cnt + 4'd1;
          end
        end
        default: begin
          state     <= ST_SEARCH;
          active    <= 1'b0;
          comma_cnt <= '0;
          idle_cnt  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ctrl_recirculador.sv
// Directed bench for ctrl_recirculador: lock, packing, partials,
// loss of lock and reset behaviour.
module tb_ctrl_recirculador;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        active;
  logic [31:0] data_out;
  logic        valid_out;
  logic        err_partial;
  logic [1:0]  state_out;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ctrl_recirculador dut (
    .clk         (clk),
    .reset       (reset),
    .byte_in     (byte_in),
    .byte_valid  (byte_valid),
    .active      (active),
    .data_out    (data_out),
    .valid_out   (valid_out),
    .err_partial (err_partial),
    .state_out   (state_out)
  );

  // Apply inputs, clock once, settle 1ns past the edge.
  task automatic step(input logic v, input logic [7:0] b);
    byte_valid = v;
    byte_in    = b;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step(1'b0, 8'h00);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 8'hBC);
      tests++;
      if ({active, valid_out, err_partial, state_out, data_out} !==
          {3'b000, 2'd0, 32'h0}) begin
        fails++;
        $display("FAIL reset[%0d] act=%b vo=%b err=%b st=%0d d=%h want 0",
                 i, active, valid_out, err_partial, state_out, data_out);
      end
    end
    reset = 1'b1;
  endtask

  task automatic test_align_pack();
    logic [7:0] w [4];
    w = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 8'hBC);
      tests++;
      if ({active, state_out} !== ((i == 3) ? 3'b1_10 : 3'b0_01)) begin
        fails++;
        $display("FAIL align comma%0d act=%b st=%0d", i + 1,
                 active, state_out);
      end
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b1, w[i]);
      tests++;
      if ({active, valid_out, err_partial} !==
          ((i == 3) ? 3'b110 : 3'b100)) begin
        fails++;
        $display("FAIL pack byte%0d act/vo/err=%b%b%b", i,
                 active, valid_out, err_partial);
      end
    end
    tests++;
    if (data_out !== 32'h11223344) begin
      fails++;
      $display("FAIL pack word got %h want 11223344", data_out);
    end
    step(1'b1, 8'hBC);
    tests++;
    if ({valid_out, err_partial, data_out} !== {2'b00, 32'h11223344}) begin
      fails++;
      $display("FAIL pack hold vo=%b err=%b d=%h want 0 0 11223344",
               valid_out, err_partial, data_out);
    end
  endtask

  task automatic test_restart();
    logic [7:0] s [8];
    s = '{8'hBC, 8'hBC, 8'hBC, 8'h55, 8'hBC, 8'hBC, 8'hBC, 8'hBC};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(1'b1, s[i]);
      tests++;
      if (active !== (i == 7)) begin
        fails++;
        $display("FAIL restart cyc%0d act=%b want %b", i + 1,
                 active, (i == 7));
      end
    end
  endtask

  task automatic test_partial();
    logic [7:0] s [7];
    s = '{8'hAA, 8'hBB, 8'hBC, 8'h01, 8'h02, 8'h03, 8'h04};
    for (int i = 0; i < 7; i++) begin
      step(1'b1, s[i]);
      tests++;
      if ({valid_out, err_partial} !==
          ((i == 2) ? 2'b01 : (i == 6) ? 2'b10 : 2'b00)) begin
        fails++;
        $display("FAIL partial step%0d vo=%b err=%b", i,
                 valid_out, err_partial);
      end
    end
    tests++;
    if (data_out !== 32'h01020304) begin
      fails++;
      $display("FAIL partial word got %h want 01020304", data_out);
    end
  endtask

  task automatic test_loss();
    step(1'b1, 8'h55);
    step(1'b1, 8'h66);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 8'h00);
      tests++;
      if ({active, valid_out, err_partial} !==
          ((i == 3) ? 3'b000 : 3'b100)) begin
        fails++;
        $display("FAIL loss idle%0d act/vo/err=%b%b%b", i + 1,
                 active, valid_out, err_partial);
      end
    end
    tests++;
    if (state_out !== 2'd0) begin
      fails++;
      $display("FAIL loss state got %0d want 0", state_out);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 8'h77);
      tests++;
      if ({active, valid_out, state_out} !== 4'b0000) begin
        fails++;
        $display("FAIL loss drop%0d act=%b vo=%b st=%0d", i,
                 active, valid_out, state_out);
      end
    end
    for (int i = 0; i < 4; i++) step(1'b1, 8'hBC);
    tests++;
    if ({active, data_out} !== {1'b1, 32'h01020304}) begin
      fails++;
      $display("FAIL loss relock act=%b d=%h want 1 01020304",
               active, data_out);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] s [8];
    s = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hB1, 8'hB2, 8'hB3, 8'hB4};
    for (int i = 0; i < 8; i++) begin
      step(1'b1, s[i]);
      tests++;
      if (valid_out !== (i == 3 || i == 7)) begin
        fails++;
        $display("FAIL b2b step%0d vo=%b", i, valid_out);
      end
      if (i == 3 || i == 7) begin
        tests++;
        if (data_out !== ((i == 3) ? 32'hA1A2A3A4 : 32'hB1B2B3B4)) begin
          fails++;
          $display("FAIL b2b word%0d got %h", i / 4, data_out);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    step(1'b1, 8'hC1);
    step(1'b1, 8'hC2);
    do_reset();
    tests++;
    if ({active, valid_out, err_partial, state_out, data_out} !==
        {3'b000, 2'd0, 32'h0}) begin
      fails++;
      $display("FAIL rstmid act=%b vo=%b err=%b st=%0d d=%h want 0",
               active, valid_out, err_partial, state_out, data_out);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 8'h10 + 8'(i));
      tests++;
      if ({active, valid_out, err_partial} !== 3'b000) begin
        fails++;
        $display("FAIL rstmid byte%0d act/vo/err=%b%b%b", i,
                 active, valid_out, err_partial);
      end
    end
  endtask

  initial begin
    reset      = 1'b0;
    byte_valid = 1'b0;
    byte_in    = 8'h00;
    test_reset();
    test_align_pack();
    test_restart();
    test_partial();
    test_loss();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ctrl_recirculador.md
Name: ctrl_recirculador

Overview:
Controller that generates the `active` qualifier and the 32-bit word stream consumed by the recirculator stage. It sits between the serial-to-parallel byte output and the recirculator.
- Acquires lane alignment by counting consecutive comma symbols.
- Once aligned, packs data bytes into 32-bit words and drives them out with a one-cycle valid.
- Drops alignment after a sustained gap in the input byte stream.

Parameters:
- COMMA, 8'hBC: alignment/idle symbol.
- ALIGN_COUNT, 4: consecutive commas required to go active; legal range 1..15.
- LOSS_COUNT, 4: consecutive cycles with byte_valid=0 in ACTIVE before alignment is dropped; legal range 1..15.

Ports:
- clk, input, 1: single clock; all state changes on posedge.
- reset, input, 1: synchronous, active-low reset, sampled on posedge clk.
- byte_in, input, 8: byte from the serial-to-parallel stage.
- byte_valid, input, 1: byte_in is meaningful this cycle.
- active, output, 1: lane aligned; drives the recirculator's active input.
- data_out, output, 32: packed word; first byte received lands in [31:24].
- valid_out, output, 1: one-cycle pulse, data_out holds a new word.
- err_partial, output, 1: one-cycle pulse, a partial word was discarded.
- state_out, output, 2: current FSM state, for debug.

Behaviour:
- All outputs are registered.
- Reset (reset==0 at posedge):
  - state=SEARCH; comma_cnt, idle_cnt and byte_idx clear to 0.
  - active=0, data_out=32'h0, valid_out=0, err_partial=0.
  - Reset has priority over every other event. Reset mid-word discards the partial word with no err_partial.
- State encoding: SEARCH=2'd0, ALIGN=2'd1, ACTIVE=2'd2; 2'd3 is illegal and recovers to SEARCH on the next edge.
- SEARCH:
  - byte_valid=1 and byte_in==COMMA: comma_cnt=1; go to ACTIVE if ALIGN_COUNT==1, else ALIGN.
  - All other inputs: stay in SEARCH; data bytes are dropped.
- ALIGN:
  - byte_valid=1 and byte_in==COMMA: comma_cnt+1. When the count reaches ALIGN_COUNT, go to ACTIVE.
  - byte_valid=1 and byte_in!=COMMA: comma_cnt=0, back to SEARCH.
  - byte_valid=0: hold state and count.
- ACTIVE:
  - active=1 starting from the edge that sampled the ALIGN_COUNT-th comma. active is 1 exactly when state==ACTIVE.
  - Data byte (byte_valid=1, byte_in!=COMMA): written into lane byte_idx, with lane 0 at [31:24]. byte_idx increments and wraps 3→0; idle_cnt clears.
  - 4th byte: on the edge sampling it, data_out takes the full word and valid_out=1 for exactly one cycle. Latency is 1 clock from the 4th byte to valid_out. data_out holds its value between pulses.
  - Comma with byte_idx==0: idle fill; no change except idle_cnt clears.
  - Comma with byte_idx!=0: partial word discarded, byte_idx=0, err_partial=1 for one cycle; stay in ACTIVE.
  - byte_valid=0: idle_cnt+1. On reaching LOSS_COUNT, go to SEARCH on that edge: active=0, partial word dropped with no err_partial, all counters clear.
- valid_out and err_partial never assert outside ACTIVE. They are mutually exclusive in any cycle.
- The first comma after returning to SEARCH counts toward realignment.

Decomposition:
- Shared package holds:
  - state encodings ST_SEARCH/ST_ALIGN/ST_ACTIVE;
  - COMMA_K28_5 = 8'hBC;
  - the default ALIGN_COUNT and LOSS_COUNT constants, reused by the serial-to-parallel block.
- One natural sub-module, `byte_packer`:
  - inputs: clk, reset, byte_in, load, clear;
  - outputs: data_out, valid_out, byte_idx;
  - the FSM stays in the top module.

Test Plan:
- Reset held low 3 cycles with byte_valid=1, byte_in=8'hBC → active=0, valid_out=0, data_out=32'h0, state_out=0 throughout.
- 4×8'hBC then 8'h11, 8'h22, 8'h33, 8'h44 → active rises on the edge of the 4th comma; one cycle after 8'h44 is sampled, valid_out=1 and data_out=32'h11223344; valid_out=0 on the next cycle.
- 3×8'hBC, 8'h55, 4×8'hBC → stays inactive after the 8'h55 (count restarts); active rises only on the 8th cycle.
- While active: 8'hAA, 8'hBB, 8'hBC → err_partial pulses once with no valid_out. Then 8'h01..8'h04 → data_out=32'h01020304 with valid_out.
- While active, after 2 data bytes, byte_valid=0 for 4 cycles → active falls on the 4th idle edge with no valid_out and no err_partial. Subsequent 8'h77 bytes are dropped until 4 commas are seen.
- While active, after 2 data bytes, reset=0 for 1 cycle → all outputs 0, state_out=0. Bytes 8'h10..8'h13 sent immediately afterwards produce no valid_out.
